// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment scan controller: feeds one registered hex decoder and the
// anode enables of NUM_DIGITS digits, with a framed valid/ready value update.
module led_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int DWELL            = 50000,
    parameter int GUARD            = 500,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      value_valid,
    output logic                      value_ready,
    input  logic                      blank_lz,
    output logic [3:0]                dec_data,
    output logic                      dec_valid,
    output logic [NUM_DIGITS-1:0]     digit_en
);

    localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic                      frame_end;

    logic [4*NUM_DIGITS-1:0]   active;
    logic [4*NUM_DIGITS-1:0]   pending;
    logic                      pend_full;
    logic [3:0]                dec_hold;

    logic [4*NUM_DIGITS-1:0]   shifted;
    logic [3:0]                cur_nib;
    logic [NUM_DIGITS-1:0]     upper_zero;
    logic                      suppress;
    logic [NUM_DIGITS-1:0]     onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GUARD;
            idx   <= '0;
            cnt   <= GUARD_LOAD;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt - CW'(1);
        frame_end = 1'b0;
        case (state)
            S_GUARD: begin
                if (cnt == '0) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = DWELL_LOAD;
                end
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = S_GUARD;
                    cnt_nxt   = GUARD_LOAD;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: state_nxt = S_GUARD;
        endcase
    end

    // The index already points at the upcoming digit during GUARD, so the
    // decoder is loaded one cycle ahead and its latency is hidden.
    always_comb begin
        shifted = active >> {idx, 2'b00};
        cur_nib = shifted[3:0];
    end

    assign dec_valid = (state == S_GUARD) && (cnt == '0) && !rst;
    assign dec_data  = dec_valid ? cur_nib : dec_hold;

    // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the active value are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
            upper_zero[NUM_DIGITS-2-k] = upper_zero[NUM_DIGITS-1-k] &&
                                         (active[4*(NUM_DIGITS-2-k) +: 4] == 4'h0);
        end
    end

    always_comb begin
        suppress = blank_lz && (idx != '0) && upper_zero[idx];
        onehot   = '0;
        if ((state == S_DRIVE) && !suppress) begin
            onehot[idx] = 1'b1;
        end
        digit_en = ANODE_ACTIVE_LOW ? ~onehot : onehot;
    end

    assign value_ready = !pend_full;

    // Transfer and accept are mutually exclusive: ready is low whenever a
    // transfer can happen, so a single priority chain covers both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            pend_full <= 1'b0;
            active    <= '0;
            dec_hold  <= '0;
        end else begin
            if (frame_end && pend_full) begin
                active    <= pending;
                pend_full <= 1'b0;
            end else if (value_valid && !pend_full) begin
                pending   <= value_in;
                pend_full <= 1'b1;
            end
            if (dec_valid) begin
                dec_hold <= dec_data;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: a frame-phase model with a pending-value queue and a
// per-frame queue of expected decoder loads, plus a registered hex decoder.
module tb_led_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int GD    = 2;
    localparam int SLOT  = DW + GD;
    localparam int FRAME = ND * SLOT;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic [15:0] value_in    = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        blank_lz    = 1'b0;
    logic [3:0]  dec_data;
    logic        dec_valid;
    logic [3:0]  digit_en;
    logic [6:0]  seg         = '1;

    int          checks = 0;
    int          errors = 0;
    int          phase  = 0;
    logic [15:0] model_active = '0;
    logic [15:0] pend_q[$];
    logic [3:0]  exp_q[$];
    logic        last_accept = 1'b0;

    led_scan_ctrl #(
        .NUM_DIGITS(ND),
        .DWELL(DW),
        .GUARD(GD),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .blank_lz(blank_lz),
        .dec_data(dec_data),
        .dec_valid(dec_valid),
        .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    // gfedcba, active-low segments for a common-anode display
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dec_valid) seg <= seg_lut(dec_data);
    end

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    function automatic logic [3:0] exp_en(input int ph, input logic [15:0] act, input logic blk);
        int slot;
        int pos;
        logic [3:0] en;
        slot = ph / SLOT;
        pos  = ph % SLOT;
        en   = 4'b1111;
        if (pos >= GD && !(blk && slot != 0 && (act >> (4 * slot)) == 16'h0)) en[slot] = 1'b0;
        return en;
    endfunction

    task automatic push_frame();
        for (int k = 0; k < ND; k++) exp_q.push_back(nib(model_active, k));
    endtask

    task automatic model_reset();
        phase        = 0;
        model_active = '0;
        pend_q.delete();
        exp_q.delete();
        push_frame();
    endtask

    task automatic tick();
        logic        full_before;
        logic        acc;
        logic [15:0] vin;
        full_before = (pend_q.size() != 0);
        acc         = value_valid && !full_before;
        vin         = value_in;
        @(posedge clk);
        #1;
        if (phase == FRAME - 1 && full_before) model_active = pend_q.pop_front();
        if (acc) pend_q.push_back(vin);
        last_accept = acc;
        phase = (phase + 1) % FRAME;
        if (phase == 0) push_frame();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        value_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (value_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", value_ready); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
        checks++; if (dec_data !== 4'h0) begin errors++; $display("FAIL reset_dec_data got %h exp 0", dec_data); end
        checks++; if (digit_en !== 4'b1111) begin errors++; $display("FAIL reset_digit_en got %b exp 1111", digit_en); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_load_display();
        do_reset();
        blank_lz = 1'b0;
        value_in = 16'h12AF;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        value_in = 16'hDEAD;
        checks++; if (value_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b exp 0", value_ready); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (digit_en !== exp_en(phase, model_active, blank_lz)) begin
                errors++; $display("FAIL load_digit_en ph=%0d got %b exp %b", phase, digit_en, exp_en(phase, model_active, blank_lz));
            end
            checks++;
            if (dec_valid !== (phase % SLOT == GD - 1)) begin
                errors++; $display("FAIL load_dec_valid ph=%0d got %b exp %b", phase, dec_valid, phase % SLOT == GD - 1);
            end
            if (dec_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL load_sb_empty ph=%0d got %h exp none", phase, dec_data);
                end else if (dec_data !== exp_q[0]) begin
                    errors++; $display("FAIL load_dec_data ph=%0d got %h exp %h", phase, dec_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (phase == GD && model_active == 16'h12AF) begin
                checks++;
                if (seg !== 7'b0001110) begin errors++; $display("FAIL load_seg_d0 got %b exp 0001110", seg); end
            end
            tick();
        end
    endtask

    task automatic test_guard_timing();
        int pulses;
        int guard_bad;
        pulses = 0;
        guard_bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (phase % SLOT < GD && digit_en !== 4'b1111) guard_bad++;
            if (dec_valid === 1'b1) begin
                pulses++;
                checks++;
                if (phase % SLOT != GD - 1) begin
                    errors++; $display("FAIL guard_pulse_pos ph=%0d got slot_pos %0d exp %0d", phase, phase % SLOT, GD - 1);
                end
                checks++;
                if (exp_q.size() == 0 || dec_data !== exp_q[0]) begin
                    errors++; $display("FAIL guard_dec_data ph=%0d got %h", phase, dec_data);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        checks++; if (pulses != ND) begin errors++; $display("FAIL guard_pulses got %0d exp %0d", pulses, ND); end
        checks++; if (guard_bad != 0) begin errors++; $display("FAIL guard_anodes got %0d bad cycles exp 0", guard_bad); end
    endtask

    task automatic test_blank(input logic [15:0] v, input logic [6:0] d0_seg);
        int lit_hi;
        do_reset();
        blank_lz = 1'b1;
        value_in = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        lit_hi = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (digit_en !== exp_en(phase, model_active, 1'b1)) begin
                errors++; $display("FAIL blank_digit_en v=%h ph=%0d got %b exp %b", v, phase, digit_en, exp_en(phase, model_active, 1'b1));
            end
            if (model_active == v) begin
                if (digit_en[3] === 1'b0 || digit_en[2] === 1'b0) lit_hi++;
                if (phase == GD) begin
                    checks++;
                    if (seg !== d0_seg) begin errors++; $display("FAIL blank_seg_d0 v=%h got %b exp %b", v, seg, d0_seg); end
                end
                if (phase == SLOT + GD && v == 16'h0030) begin
                    checks++;
                    if (seg !== 7'b0110000 || digit_en !== 4'b1101) begin
                        errors++; $display("FAIL blank_d1 got seg %b en %b exp 0110000 1101", seg, digit_en);
                    end
                end
            end
            tick();
        end
        checks++; if (lit_hi != 0) begin errors++; $display("FAIL blank_hi_lit v=%h got %0d exp 0", v, lit_hi); end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc_phase;
        bit got;
        do_reset();
        blank_lz = 1'b0;
        value_in = 16'h1111;
        value_valid = 1'b1;
        tick();
        value_in = 16'h2222;
        got = 0;
        acc_phase = -1;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            checks++;
            if (value_ready !== (pend_q.size() == 0)) begin
                errors++; $display("FAIL b2b_ready ph=%0d got %b exp %b", phase, value_ready, pend_q.size() == 0);
            end
            if (dec_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || dec_data !== exp_q[0]) begin errors++; $display("FAIL b2b_dec_data ph=%0d got %h", phase, dec_data); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
            if (last_accept && value_in == 16'h2222) begin
                got = 1;
                acc_phase = phase;
            end
        end
        value_valid = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL b2b_timeout got no accept exp accept"); end
        checks++; if (acc_phase != 1) begin errors++; $display("FAIL b2b_accept_phase got %0d exp 1", acc_phase); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (dec_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || dec_data !== exp_q[0]) begin errors++; $display("FAIL b2b_frame ph=%0d got %h", phase, dec_data); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        checks++; if (model_active != 16'h2222) begin errors++; $display("FAIL b2b_final got %h exp 2222", model_active); end
    endtask

    task automatic test_midrun_reset();
        bit found;
        do_reset();
        value_in = 16'h2222;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            if (model_active == 16'h2222 && phase == 2 * SLOT + GD + 1) found = 1;
            else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL mrst_timeout got no digit2 slot exp found"); end
        value_in = 16'h5555;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        checks++; if (digit_en !== 4'b1011) begin errors++; $display("FAIL mrst_pre_en got %b exp 1011", digit_en); end
        checks++; if (value_ready !== 1'b0) begin errors++; $display("FAIL mrst_pre_ready got %b exp 0", value_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (digit_en !== 4'b1111) begin errors++; $display("FAIL mrst_async_en got %b exp 1111", digit_en); end
        checks++; if (value_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b exp 1", value_ready); end
        #2 rst = 1'b0;
        model_reset();
        checks++; if (digit_en !== 4'b1111 || dec_valid !== 1'b0) begin errors++; $display("FAIL mrst_g0 got en %b v %b exp 1111 0", digit_en, dec_valid); end
        tick();
        checks++; if (digit_en !== 4'b1111 || dec_valid !== 1'b1 || dec_data !== 4'h0) begin
            errors++; $display("FAIL mrst_g1 got en %b v %b d %h exp 1111 1 0", digit_en, dec_valid, dec_data);
        end
        tick();
        checks++; if (digit_en !== 4'b1110 || seg !== 7'b1000000) begin
            errors++; $display("FAIL mrst_d0 got en %b seg %b exp 1110 1000000", digit_en, seg);
        end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_guard_timing();
        test_blank(16'h0030, 7'b1000000);
        test_blank(16'h0000, 7'b1000000);
        test_back_to_back();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
